// File: rtl/wb_bram_sched_pkg.sv
// wb_bram_sched_pkg: shared types and helpers for the BRAM write-port scheduler.
//   BRAM_ADDR_W / BRAM_WORD_W : default BRAM address and word widths.
//   wbs_state_e               : scheduler FSM encoding (idle / run / done).
//   region_len()              : length of the address region a layer covers.
package wb_bram_sched_pkg;

    localparam int BRAM_ADDR_W = 12;
    localparam int BRAM_WORD_W = 64;

    typedef enum logic [1:0] {
        WBS_IDLE = 2'd0,
        WBS_RUN  = 2'd1,
        WBS_DONE = 2'd2
    } wbs_state_e;

    // Rows times the effective stride; a stride shorter than a row still
    // covers every word of that row.
    function automatic logic [31:0] region_len(logic [7:0] rows, logic [7:0] row_words,
                                               logic [31:0] stride);
        logic [31:0] s;
        s = (stride > {24'd0, row_words}) ? stride : {24'd0, row_words};
        return 32'(rows) * s;
    endfunction

endpackage

// File: rtl/wb_bram_sched_if.sv
// wb_bram_sched_if: writeback, loader and BRAM write-port bundle.
//   wb_*   : writeback packer request (valid, two data words) and ready.
//   ld_*   : loader request (valid, port select, address, data) and ready.
//   *_BRAM32k_{1,2} : registered write enable / address / data per BRAM port.
//   modport slave  : the scheduler side.
//   modport master : the requesters and BRAM side.
interface wb_bram_sched_if
    import wb_bram_sched_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_WORD_W
);
    logic              wb_valid;
    logic [DATA_W-1:0] wb_din_1;
    logic [DATA_W-1:0] wb_din_2;
    logic              wb_ready;
    logic              ld_valid;
    logic              ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_din;
    logic              ld_ready;
    logic              we_BRAM32k_1;
    logic              we_BRAM32k_2;
    logic [ADDR_W-1:0] addr_BRAM32k_1;
    logic [ADDR_W-1:0] addr_BRAM32k_2;
    logic [DATA_W-1:0] din_BRAM32k_1;
    logic [DATA_W-1:0] din_BRAM32k_2;

    modport slave (
        input  wb_valid, wb_din_1, wb_din_2, ld_valid, ld_sel, ld_addr, ld_din,
        output wb_ready, ld_ready, we_BRAM32k_1, we_BRAM32k_2,
               addr_BRAM32k_1, addr_BRAM32k_2, din_BRAM32k_1, din_BRAM32k_2
    );

    modport master (
        output wb_valid, wb_din_1, wb_din_2, ld_valid, ld_sel, ld_addr, ld_din,
        input  wb_ready, ld_ready, we_BRAM32k_1, we_BRAM32k_2,
               addr_BRAM32k_1, addr_BRAM32k_2, din_BRAM32k_1, din_BRAM32k_2
    );

endinterface

// File: rtl/wb_bram_addr_gen.sv
// wb_bram_addr_gen: row/column walker producing the two writeback addresses.
//   clk, rst          : clock, asynchronous active-high reset.
//   load              : restart at base_1/base_2 with row and column 0.
//   step              : advance one word (one accepted writeback pair).
//   base_1, base_2    : start addresses sampled on load.
//   row_words, rows   : layer geometry (both >= 1).
//   stride            : address step between row starts.
//   addr_1, addr_2    : current write addresses (row base + column).
//   last              : current word is the final word of the layer.
module wb_bram_addr_gen
    import wb_bram_sched_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_1,
    input  logic [ADDR_W-1:0] base_2,
    input  logic [7:0]        row_words,
    input  logic [7:0]        rows,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr_1,
    output logic [ADDR_W-1:0] addr_2,
    output logic              last
);

    logic [7:0]        col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] row_base_1_q, row_base_1_d, row_base_2_q, row_base_2_d;
    logic              col_end, row_end;

    always_comb begin
        col_end      = col_q == row_words - 8'd1;
        row_end      = row_q == rows - 8'd1;
        last         = col_end && row_end;
        col_d        = load ? 8'd0 : step ? (col_end ? 8'd0 : col_q + 8'd1) : col_q;
        row_d        = load ? 8'd0 : (step && col_end) ? row_q + 8'd1 : row_q;
        row_base_1_d = load ? base_1 : (step && col_end) ? row_base_1_q + stride : row_base_1_q;
        row_base_2_d = load ? base_2 : (step && col_end) ? row_base_2_q + stride : row_base_2_q;
        addr_1       = row_base_1_q + ADDR_W'(col_q);
        addr_2       = row_base_2_q + ADDR_W'(col_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            row_base_1_q <= '0;
            row_base_2_q <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_1_q <= row_base_1_d;
            row_base_2_q <= row_base_2_d;
        end
    end

endmodule

// File: rtl/wb_bram_sched.sv
// wb_bram_sched: write-port scheduler for the dual-port 32k BRAM.
//   clk, rst      : clock, asynchronous active-high reset.
//   start         : begins a layer when idle (ignored while busy).
//   cfg_*         : layer base addresses, geometry and row stride.
//   bus (slave)   : writeback / loader handshakes and registered BRAM writes.
//   busy          : a layer is in progress.
//   FinishWB      : one-cycle pulse when a layer completes.
//   ld_err        : pulse one cycle after a loader write into the active
//                   region was dropped; only with WBSCHED_PROTECT_EN defined,
//                   otherwise constant 0.
module wb_bram_sched
    import wb_bram_sched_pkg::*;
#(
    parameter int ADDR_W     = BRAM_ADDR_W,
    parameter int DATA_W     = BRAM_WORD_W,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_1,
    input  logic [ADDR_W-1:0] cfg_base_2,
    input  logic [7:0]        cfg_row_words,
    input  logic [7:0]        cfg_rows,
    input  logic [ADDR_W-1:0] cfg_stride,
    wb_bram_sched_if.slave    bus,
    output logic              busy,
    output logic              FinishWB,
    output logic              ld_err
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    wbs_state_e        state_q, state_d;
    logic [7:0]        words_q, words_d, rows_q, rows_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              en_q;
    logic              we_1_q, we_1_d, we_2_q, we_2_d, ld_err_q, ld_err_d;
    logic [ADDR_W-1:0] addr_1_q, addr_1_d, addr_2_q, addr_2_d;
    logic [DATA_W-1:0] din_1_q, din_1_d, din_2_q, din_2_d;
    logic [ADDR_W-1:0] gen_addr_1, gen_addr_2;
    logic              last, force_ld, wb_acc, ld_acc, ld_w1, ld_w2, load, prot;

    // en_q keeps both readies low while reset is held and for the first cycle after.
    assign force_ld     = state_q == WBS_RUN && starve_q == SW'(STARVE_LIM);
    assign bus.wb_ready = state_q == WBS_RUN && !force_ld;
    assign bus.ld_ready = en_q && (state_q != WBS_RUN || force_ld || !bus.wb_valid);
    assign wb_acc       = bus.wb_valid && bus.wb_ready;
    assign ld_acc       = bus.ld_valid && bus.ld_ready;
    assign load         = state_q == WBS_IDLE && start;

`ifdef WBSCHED_PROTECT_EN
    logic [ADDR_W-1:0] base_1_q, base_1_d, base_2_q, base_2_d, ld_off;

    always_comb begin
        base_1_d = load ? cfg_base_1 : base_1_q;
        base_2_d = load ? cfg_base_2 : base_2_q;
        ld_off   = bus.ld_addr - (bus.ld_sel ? base_2_q : base_1_q);
        prot     = state_q == WBS_RUN &&
                   32'(ld_off) < region_len(rows_q, words_q, 32'(stride_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_1_q <= '0;
            base_2_q <= '0;
        end else begin
            base_1_q <= base_1_d;
            base_2_q <= base_2_d;
        end
    end
`else
    assign prot = 1'b0;
`endif

    always_comb begin
        state_d  = state_q == WBS_IDLE ? (start ? WBS_RUN : WBS_IDLE)
                 : state_q == WBS_RUN  ? ((wb_acc && last) ? WBS_DONE : WBS_RUN)
                 : WBS_IDLE;
        words_d  = load ? cfg_row_words : words_q;
        rows_d   = load ? cfg_rows : rows_q;
        stride_d = load ? cfg_stride : stride_q;
        starve_d = (ld_acc || !bus.ld_valid) ? '0 : starve_q + 1'b1;
        ld_w1    = ld_acc && !bus.ld_sel && !prot;
        ld_w2    = ld_acc && bus.ld_sel && !prot;
        we_1_d   = wb_acc || ld_w1;
        we_2_d   = wb_acc || ld_w2;
        addr_1_d = wb_acc ? gen_addr_1 : ld_w1 ? bus.ld_addr : addr_1_q;
        addr_2_d = wb_acc ? gen_addr_2 : ld_w2 ? bus.ld_addr : addr_2_q;
        din_1_d  = wb_acc ? bus.wb_din_1 : ld_w1 ? bus.ld_din : din_1_q;
        din_2_d  = wb_acc ? bus.wb_din_2 : ld_w2 ? bus.ld_din : din_2_q;
        ld_err_d = ld_acc && prot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WBS_IDLE;
            en_q     <= 1'b0;
            words_q  <= '0;
            rows_q   <= '0;
            stride_q <= '0;
            starve_q <= '0;
            we_1_q   <= 1'b0;
            we_2_q   <= 1'b0;
            addr_1_q <= '0;
            addr_2_q <= '0;
            din_1_q  <= '0;
            din_2_q  <= '0;
            ld_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= 1'b1;
            words_q  <= words_d;
            rows_q   <= rows_d;
            stride_q <= stride_d;
            starve_q <= starve_d;
            we_1_q   <= we_1_d;
            we_2_q   <= we_2_d;
            addr_1_q <= addr_1_d;
            addr_2_q <= addr_2_d;
            din_1_q  <= din_1_d;
            din_2_q  <= din_2_d;
            ld_err_q <= ld_err_d;
        end
    end

    wb_bram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (wb_acc),
        .base_1    (cfg_base_1),
        .base_2    (cfg_base_2),
        .row_words (words_q),
        .rows      (rows_q),
        .stride    (stride_q),
        .addr_1    (gen_addr_1),
        .addr_2    (gen_addr_2),
        .last      (last)
    );

    assign busy               = state_q != WBS_IDLE;
    assign FinishWB           = state_q == WBS_DONE;
    assign ld_err             = ld_err_q;
    assign bus.we_BRAM32k_1   = we_1_q;
    assign bus.we_BRAM32k_2   = we_2_q;
    assign bus.addr_BRAM32k_1 = addr_1_q;
    assign bus.addr_BRAM32k_2 = addr_2_q;
    assign bus.din_BRAM32k_1  = din_1_q;
    assign bus.din_BRAM32k_2  = din_2_q;

endmodule

// File: tb/tb_wb_bram_sched.sv
// tb_wb_bram_sched: scoreboard bench for wb_bram_sched (directed layers, arbitration, reset abort).
module tb_wb_bram_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] cfg_base_1 = '0, cfg_base_2 = '0, cfg_stride = '0;
    logic [7:0]  cfg_row_words = 8'd1, cfg_rows = 8'd1;
    logic        busy, FinishWB, ld_err;

    wb_bram_sched_if #(.ADDR_W(12), .DATA_W(64)) bus();

    wb_bram_sched #(.ADDR_W(12), .DATA_W(64), .STARVE_LIM(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_base_1    (cfg_base_1),
        .cfg_base_2    (cfg_base_2),
        .cfg_row_words (cfg_row_words),
        .cfg_rows      (cfg_rows),
        .cfg_stride    (cfg_stride),
        .bus           (bus),
        .busy          (busy),
        .FinishWB      (FinishWB),
        .ld_err        (ld_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we1, we2;
        logic [11:0] a1, a2;
        logic [63:0] d1, d2;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  n_chk = 0, n_pass = 0, fin_cnt = 0, err_cnt = 0, wb_k = 0, ld_k = 0;

    function automatic logic [63:0] pat1(int k);
        return 64'h1111_AAAA_0000_0000 + 64'(k);
    endfunction

    function automatic logic [63:0] pat2(int k);
        return 64'h2222_BBBB_0000_0000 + 64'(k);
    endfunction

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_wb(logic [11:0] a1, logic [11:0] a2, int k);
        exp_q.push_back('{1'b1, 1'b1, a1, a2, pat1(k), pat2(k)});
    endtask

    task automatic expect_ld(logic sel, logic [11:0] a, logic [63:0] d);
        exp_q.push_back('{!sel, sel, a, a, d, d});
    endtask

    // Scoreboard monitor: every BRAM write pops and checks one expectation.
    always @(negedge clk) begin
        if (FinishWB) fin_cnt++;
        if (ld_err) err_cnt++;
        if (bus.we_BRAM32k_1 || bus.we_BRAM32k_2) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {bus.we_BRAM32k_1, bus.we_BRAM32k_2}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("write_enables", {bus.we_BRAM32k_1, bus.we_BRAM32k_2}, {e.we1, e.we2});
                if (e.we1) chk("port1_addr_data", {bus.addr_BRAM32k_1, bus.din_BRAM32k_1}, {e.a1, e.d1});
                if (e.we2) chk("port2_addr_data", {bus.addr_BRAM32k_2, bus.din_BRAM32k_2}, {e.a2, e.d2});
            end
        end
    end

    task automatic cfg_set(logic [11:0] b1, logic [11:0] b2, logic [7:0] n, logic [7:0] r,
                           logic [11:0] s);
        cfg_base_1    = b1;
        cfg_base_2    = b2;
        cfg_row_words = n;
        cfg_rows      = r;
        cfg_stride    = s;
    endtask

    task automatic cfg_garbage();
        cfg_set(12'h555, 12'hAAA, 8'd1, 8'd1, 12'h003);
    endtask

    task automatic start_layer(logic [11:0] b1, logic [11:0] b2, logic [7:0] n, logic [7:0] r,
                               logic [11:0] s);
        cfg_set(b1, b2, n, r, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_garbage();
    endtask

    task automatic run(int n_wb, logic with_ld);
        int guard = 0;
        wb_k = 0;
        ld_k = 0;
        bus.wb_din_1 = pat1(0);
        bus.wb_din_2 = pat2(0);
        bus.wb_valid = 1'b1;
        bus.ld_valid = with_ld;
        while (wb_k < n_wb && guard < 300) begin
            @(negedge clk);
            if (bus.wb_valid && bus.wb_ready) wb_k++;
            else if (bus.ld_valid && bus.ld_ready) ld_k++;
            @(posedge clk); #1;
            guard++;
            bus.wb_din_1 = pat1(wb_k);
            bus.wb_din_2 = pat2(wb_k);
        end
        bus.wb_valid = 1'b0;
        bus.ld_valid = 1'b0;
        chk("wb_accepts", wb_k, n_wb);
    endtask

    task automatic ld_req(logic sel, logic [11:0] a, logic [63:0] d);
        int  guard = 0;
        logic acc = 1'b0;
        bus.ld_sel   = sel;
        bus.ld_addr  = a;
        bus.ld_din   = d;
        bus.ld_valid = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = bus.ld_ready;
            @(posedge clk); #1;
            guard++;
        end
        bus.ld_valid = 1'b0;
        chk("ld_accept", acc, 1);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("idle_after_layer", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fin_before;
        logic [11:0] t2_a1 [6];
        logic [11:0] t2_a2 [6];
        t2_a1 = '{12'h100, 12'h101, 12'h110, 12'h111, 12'h120, 12'h121};
        t2_a2 = '{12'h900, 12'h901, 12'h910, 12'h911, 12'h920, 12'h921};
        bus.wb_valid = 1'b0;
        bus.wb_din_1 = '0;
        bus.wb_din_2 = '0;
        bus.ld_valid = 1'b0;
        bus.ld_sel   = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_din   = '0;

        @(negedge clk);
        chk("reset_outputs", {bus.we_BRAM32k_1, bus.we_BRAM32k_2, busy, FinishWB, ld_err,
                              bus.wb_ready, bus.ld_ready, bus.addr_BRAM32k_1, bus.din_BRAM32k_2}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", {bus.wb_ready, bus.ld_ready}, 2'b01);

        // Single row of 5 words on both ports.
        for (int i = 0; i < 5; i++) expect_wb(12'(i), 12'h800 + 12'(i), i);
        start_layer(12'h000, 12'h800, 8'd5, 8'd1, 12'h000);
        run(5, 1'b0);
        @(negedge clk);
        chk("finish_pulse", FinishWB, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("finish_clear", FinishWB, 0);
        chk("busy_back_idle", busy, 0);
        drain();

        // Three rows of two words with stride 0x10; a start while busy is ignored.
        for (int i = 0; i < 6; i++) expect_wb(t2_a1[i], t2_a2[i], i);
        start_layer(12'h100, 12'h900, 8'd2, 8'd3, 12'h010);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run(6, 1'b0);
        drain();

        // Address wrap, with a loader write accepted in the start cycle.
        expect_ld(1'b1, 12'h7AB, 64'hCAFE_0000_0000_0001);
        expect_wb(12'hFFE, 12'h7FE, 0);
        expect_wb(12'hFFF, 12'h7FF, 1);
        expect_wb(12'h000, 12'h800, 2);
        expect_wb(12'h001, 12'h801, 3);
        cfg_set(12'hFFE, 12'h7FE, 8'd4, 8'd1, 12'h000);
        bus.ld_sel   = 1'b1;
        bus.ld_addr  = 12'h7AB;
        bus.ld_din   = 64'hCAFE_0000_0000_0001;
        bus.ld_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.ld_valid = 1'b0;
        cfg_garbage();
        chk("busy_after_start_with_ld", busy, 1);
        run(4, 1'b0);
        drain();

        // Both requesters held high: loader forced in on every 9th RUN cycle.
        for (int i = 0; i < 20; i++) begin
            expect_wb(12'h200 + 12'(i), 12'h300 + 12'(i), i);
            if (i == 7 || i == 15) expect_ld(1'b0, 12'h050, 64'hDDDD_0000_0000_0001);
        end
        bus.ld_sel  = 1'b0;
        bus.ld_addr = 12'h050;
        bus.ld_din  = 64'hDDDD_0000_0000_0001;
        start_layer(12'h200, 12'h300, 8'd20, 8'd1, 12'h000);
        run(20, 1'b1);
        chk("starve_ld_grants", ld_k, 2);
        drain();

        // Reset after the 3rd accept of a 10-word layer, then restart.
        for (int i = 0; i < 3; i++) expect_wb(12'h020 + 12'(i), 12'hA00 + 12'(i), i);
        start_layer(12'h020, 12'hA00, 8'd10, 8'd1, 12'h000);
        run(3, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_outputs", {bus.we_BRAM32k_1, bus.we_BRAM32k_2, busy, FinishWB,
                              bus.wb_ready, bus.ld_ready, bus.addr_BRAM32k_1, bus.addr_BRAM32k_2}, 0);
        fin_before = fin_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_finish_after_abort", fin_cnt, fin_before);
        chk("idle_after_abort", busy, 0);
        chk("abort_queue_empty", exp_q.size(), 0);
        expect_wb(12'h020, 12'hA00, 0);
        expect_wb(12'h021, 12'hA01, 1);
        start_layer(12'h020, 12'hA00, 8'd2, 8'd1, 12'h000);
        run(2, 1'b0);
        drain();

        // Loader writes during RUN: inside and just below the active region.
        start_layer(12'h300, 12'hB00, 8'd4, 8'd2, 12'h002);
`ifndef WBSCHED_PROTECT_EN
        expect_ld(1'b0, 12'h301, 64'hEEEE_0000_0000_0001);
`endif
        ld_req(1'b0, 12'h301, 64'hEEEE_0000_0000_0001);
        @(negedge clk);
`ifdef WBSCHED_PROTECT_EN
        chk("protect_err", ld_err, 1);
        chk("protect_no_we", bus.we_BRAM32k_1, 0);
`else
        chk("unprotected_no_err", ld_err, 0);
`endif
        @(posedge clk); #1;
        expect_ld(1'b0, 12'h2FF, 64'hEEEE_0000_0000_0002);
        ld_req(1'b0, 12'h2FF, 64'hEEEE_0000_0000_0002);
        @(negedge clk);
        chk("outside_region_no_err", ld_err, 0);
        @(posedge clk); #1;
        expect_wb(12'h300, 12'hB00, 0);
        expect_wb(12'h301, 12'hB01, 1);
        expect_wb(12'h302, 12'hB02, 2);
        expect_wb(12'h303, 12'hB03, 3);
        expect_wb(12'h302, 12'hB02, 4);
        expect_wb(12'h303, 12'hB03, 5);
        expect_wb(12'h304, 12'hB04, 6);
        expect_wb(12'h305, 12'hB05, 7);
        run(8, 1'b0);
        drain();

        chk("finish_total", fin_cnt, 6);
`ifdef WBSCHED_PROTECT_EN
        chk("err_total", err_cnt, 1);
`else
        chk("err_total", err_cnt, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_bram_sched.md
Name: wb_bram_sched

Overview:
- Write-port scheduler for the dual-port 32k BRAM, fed by the writeback packer and the host/input loader.
- Sequences one layer's writeback: walks row/column addresses from a configured base and stride, and accepts one packed 64-bit word pair per grant.
- Arbitrates BRAM write access between the writeback stream (WB) and the loader (LD), then signals layer completion with FinishWB.

Parameters:
- ADDR_W, 12, BRAM word address width.
- DATA_W, 64, BRAM word width (8 packed bytes).
- STARVE_LIM, 8, consecutive cycles LD may wait in RUN before it gets a forced grant.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a layer when IDLE.
- cfg_base_1  in  ADDR_W  port-1 start address.
- cfg_base_2  in  ADDR_W  port-2 start address.
- cfg_row_words  in  8  words per row (N>=1).
- cfg_rows  in  8  rows per layer (R>=1).
- cfg_stride  in  ADDR_W  address step between row starts.
- wb_valid  in  1  packer has a word pair.
- wb_din_1  in  DATA_W  port-1 data.
- wb_din_2  in  DATA_W  port-2 data.
- wb_ready  out  1  WB accepted this cycle.
- ld_valid  in  1  loader request.
- ld_sel  in  1  0=port 1, 1=port 2.
- ld_addr  in  ADDR_W  loader address.
- ld_din  in  DATA_W  loader data.
- ld_ready  out  1  LD accepted this cycle.
- we_BRAM32k_1  out  1  port-1 write enable.
- we_BRAM32k_2  out  1  port-2 write enable.
- addr_BRAM32k_1  out  ADDR_W  port-1 address.
- addr_BRAM32k_2  out  ADDR_W  port-2 address.
- din_BRAM32k_1  out  DATA_W  port-1 data.
- din_BRAM32k_2  out  DATA_W  port-2 data.
- busy  out  1  state != IDLE.
- FinishWB  out  1  one-cycle pulse on layer completion.
- ld_err  out  1  protected-write drop pulse (optional feature).

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0. An asynchronous rst mid-layer aborts the layer with no FinishWB.
- Handshakes: accept = valid & ready. ready is combinational from state/arbiter and does not depend on the same cycle's valid. At most one requester is accepted per cycle.
- Latency: the BRAM write is registered and appears exactly 1 cycle after accept. we_* are high for one cycle per accept.
- WB accept drives both we_1 and we_2 with the current addr_1/addr_2. LD accept drives only the selected port's we, with ld_addr and ld_din.
- FSM IDLE: wb_ready=0; ld_ready=1. On start, latch cfg_*, set row_base_x=cfg_base_x, col=0, row=0, then go to RUN.
- FSM RUN: on WB accept, write at row_base_x+col.
  - col<N-1: col++.
  - col=N-1, row<R-1: col=0, row++, row_base_x += cfg_stride.
  - col=N-1, row=R-1: go to DONE.
- FSM DONE: one cycle. FinishWB=1, no WB grant, LD grant allowed; then go to IDLE.
- Arbitration in RUN: WB has priority. starve_cnt increments each cycle ld_valid is high and LD is not granted. When starve_cnt=STARVE_LIM, LD is granted that cycle instead of WB (wb_ready=0), and starve_cnt clears. starve_cnt also clears on any LD grant or when ld_valid is low.
- Address arithmetic: all sums are modulo 2^ADDR_W (wrap 4095->0, no error).
- start while busy is ignored. start in the same cycle as ld_valid in IDLE: LD is accepted and the FSM enters RUN.
- cfg_* changes while busy have no effect on the running layer.

Optional Feature:
- Macro WBSCHED_PROTECT_EN.
- Defined: in RUN, an LD request whose port's address lies within the active region is accepted but not written (we stays 0), and ld_err pulses 1 cycle later.
  - Active region: offset (ld_addr - cfg_base_sel) mod 2^ADDR_W < R*stride_eff.
  - stride_eff = max(cfg_stride, N).
- Not defined: no check is performed, and ld_err is tied to 0.

Decomposition:
- defines.v gets the FSM encodings `WbsIdle/`WbsRun/`WbsDone (2-bit) and the `BramAddr/`BramWord width macros.
- One sub-module, wb_bram_addr_gen: row/column counters and the two row_base registers, with step/last outputs.
- The arbiter and FSM stay in the top module.

Test Plan:
- N=5, R=1, base1=0x000, base2=0x800, wb_valid held high -> writes at 0x000..0x004 and 0x800..0x804 on consecutive cycles; FinishWB on the cycle after the 5th accept; busy returns to 0.
- N=2, R=3, stride=0x010, base1=0x100 -> port-1 addrs 0x100, 0x101, 0x110, 0x111, 0x120, 0x121.
- base1=0xFFE, N=4 -> addrs 0xFFE, 0xFFF, 0x000, 0x001; no error.
- RUN with wb_valid and ld_valid both held high, STARVE_LIM=8 -> LD granted on the 9th cycle, WB stalls 1 cycle; repeats every 9 cycles.
- rst asserted after the 3rd accept of a 10-word layer -> outputs 0 immediately, no FinishWB; the next start restarts at base.
- With WBSCHED_PROTECT_EN, LD to base1+1 during RUN -> no we_1, ld_err=1; LD to base1-1 -> written normally.
